// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timing blocks: FSM encoding, default sizes and
// the duration clamp used on load.
package traffic_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } timer_state_e;

  localparam int unsigned DefTickDiv = 100;
  localparam int unsigned DefCntW    = 7;
  localparam int unsigned DefMaxVal  = 99;
  localparam int unsigned DefWarnVal = 3;

  // Saturate a requested duration to the largest value the phase timer accepts.
  function automatic int unsigned clamp_val(input int unsigned val, input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second strobe; tick_pre is high on the last cycle of each second.
module tick_prescaler #(
  parameter int unsigned pTICK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick_pre
);

  localparam int unsigned PreW = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(pTICK_DIV - 1);

  logic [PreW-1:0] pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (clr) begin
      pre_q <= '0;
    end else if (run) begin
      if (pre_q == PreLast) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PreW'(1);
      end
    end
  end

  // With a divider of 1, PreLast is 0 and every running cycle is a terminal count.
  assign tick_pre = run && (pre_q == PreLast);

endmodule

// File: rtl/phase_timer.sv
// Per-phase seconds down-counter: loaded by the sequencing FSM, counts out whole seconds and
// flags the closing seconds of the phase for the display logic.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned pTICK_DIV = DefTickDiv,
  parameter int unsigned pCNT_W    = DefCntW,
  parameter int unsigned pMAX_VAL  = DefMaxVal,
  parameter int unsigned pWARN_VAL = DefWarnVal
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [pCNT_W-1:0] load_val,
  output logic [pCNT_W-1:0] count,
  output logic              tick,
  output logic              done,
  output logic              busy,
  output logic              last,
  output logic              pre_last,
  output logic              warn
);

  if (pTICK_DIV < 1) begin : g_bad_tick_div
    $error("phase_timer: pTICK_DIV must be at least 1");
  end
  if ((pMAX_VAL >> pCNT_W) != 0) begin : g_bad_max_val
    $error("phase_timer: pMAX_VAL does not fit in pCNT_W bits");
  end
  if (pWARN_VAL > pMAX_VAL) begin : g_bad_warn_val
    $error("phase_timer: pWARN_VAL must not exceed pMAX_VAL");
  end

  timer_state_e      state_q;
  logic [pCNT_W-1:0] count_q;
  logic              tick_q;
  logic              done_q;
  logic [pCNT_W-1:0] load_clamped;
  logic              pre_run;
  logic              pre_clr;
  logic              tick_pre;

  assign load_clamped = pCNT_W'(clamp_val(32'(load_val), pMAX_VAL));

  // The prescaler only advances while running unpaused; a load or idle parks it at phase 0.
  assign pre_run = (state_q == StRun) && en && !load;
  assign pre_clr = load || (state_q == StIdle);

  tick_prescaler #(
    .pTICK_DIV(pTICK_DIV)
  ) u_tick_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (pre_run),
    .clr     (pre_clr),
    .tick_pre(tick_pre)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (load) begin
        // A load wins over any tick this cycle, so a reload on the final second never completes.
        count_q <= load_clamped;
        state_q <= (load_clamped != '0) ? StRun : StIdle;
      end else if (state_q == StRun && tick_pre) begin
        tick_q <= 1'b1;
        if (count_q <= pCNT_W'(1)) begin
          count_q <= '0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end else begin
          count_q <= count_q - pCNT_W'(1);
        end
      end
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign done     = done_q;
  assign busy     = (state_q == StRun);
  assign last     = busy && (count_q == pCNT_W'(1));
  assign pre_last = busy && (count_q == pCNT_W'(2));
  assign warn     = busy && (count_q != '0) && (count_q <= pCNT_W'(pWARN_VAL));

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: a divide-by-4 and a divide-by-1 instance share stimulus; a cycle
// model queues expected outputs for every edge and directed checks pin the key latencies.
module tb_phase_timer;

  typedef struct packed {
    logic [6:0] count;
    logic       tick;
    logic       done;
    logic       busy;
    logic       last;
    logic       pre_last;
    logic       warn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_val = '0;

  logic [6:0] count4, count1;
  logic tick4, done4, busy4, last4, pre_last4, warn4;
  logic tick1, done1, busy1, last1, pre_last1, warn1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int load_cyc = 0;

  exp_t q4[$];
  exp_t q1[$];

  int unsigned m_cnt[2];
  int unsigned m_pre[2];
  bit          m_run[2];
  int unsigned m_div[2] = '{4, 1};

  always #5 clk = ~clk;

  phase_timer #(
    .pTICK_DIV(4),
    .pCNT_W   (7),
    .pMAX_VAL (99),
    .pWARN_VAL(3)
  ) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .count   (count4),
    .tick    (tick4),
    .done    (done4),
    .busy    (busy4),
    .last    (last4),
    .pre_last(pre_last4),
    .warn    (warn4)
  );

  phase_timer #(
    .pTICK_DIV(1),
    .pCNT_W   (7),
    .pMAX_VAL (99),
    .pWARN_VAL(3)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .count   (count1),
    .tick    (tick1),
    .done    (done1),
    .busy    (busy1),
    .last    (last1),
    .pre_last(pre_last1),
    .warn    (warn1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
      m_run[k] = 1'b0;
    end
  endtask

  // Next-edge behaviour of one instance, derived from the current inputs.
  task automatic model_step(input int k, output exp_t e);
    bit t = 1'b0;
    bit d = 1'b0;
    if (load) begin
      m_cnt[k] = (load_val > 7'd99) ? 99 : int'(load_val);
      m_pre[k] = 0;
      m_run[k] = (m_cnt[k] != 0);
    end else if (m_run[k] && en) begin
      if (m_pre[k] + 1 == m_div[k]) begin
        m_pre[k] = 0;
        t = 1'b1;
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          d = 1'b1;
          m_run[k] = 1'b0;
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end else if (!m_run[k]) begin
      m_pre[k] = 0;
    end
    e.count    = 7'(m_cnt[k]);
    e.tick     = t;
    e.done     = d;
    e.busy     = m_run[k];
    e.last     = m_run[k] && (m_cnt[k] == 1);
    e.pre_last = m_run[k] && (m_cnt[k] == 2);
    e.warn     = m_run[k] && (m_cnt[k] >= 1) && (m_cnt[k] <= 3);
  endtask

  task automatic compare(input string who, input exp_t got, input exp_t exp);
    check({who, "_count"}, 32'(got.count), 32'(exp.count));
    check({who, "_tick"}, 32'(got.tick), 32'(exp.tick));
    check({who, "_done"}, 32'(got.done), 32'(exp.done));
    check({who, "_busy"}, 32'(got.busy), 32'(exp.busy));
    check({who, "_last"}, 32'(got.last), 32'(exp.last));
    check({who, "_pre_last"}, 32'(got.pre_last), 32'(exp.pre_last));
    check({who, "_warn"}, 32'(got.warn), 32'(exp.warn));
  endtask

  task automatic step();
    exp_t e;
    exp_t g4;
    exp_t g1;
    model_step(0, e);
    q4.push_back(e);
    model_step(1, e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g4 = '{count4, tick4, done4, busy4, last4, pre_last4, warn4};
    g1 = '{count1, tick1, done1, busy1, last1, pre_last1, warn1};
    compare("d4", g4, q4.pop_front());
    compare("d1", g1, q1.pop_front());
  endtask

  task automatic load_step(input logic [6:0] val);
    load = 1'b1;
    load_val = val;
    step();
    load = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d4"}, 32'({count4, tick4, done4, busy4, last4, pre_last4, warn4}), 32'd0);
    check({tag, "_d1"}, 32'({count1, tick1, done1, busy1, last1, pre_last1, warn1}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cyc;
    int n_done;
    int gap;
    int n_tick;
    model_clear();

    // Reset state
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    check("rst_idle_no_tick", 32'(tick4), 32'd0);

    // 1: plain 5-second phase
    load_step(7'd5);
    check("t1_load_cnt", 32'(count4), 32'd5);
    done_cyc = load_cyc + 999;
    n_done = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      if (done4) begin
        n_done++;
        if (n_done == 1) done_cyc = cyc;
      end
    end
    check("t1_done_lat", 32'(done_cyc - load_cyc), 32'd20);
    check("t1_done_cnt", 32'(n_done), 32'd1);

    // 2: pause for 7 cycles at count 3
    load_step(7'd5);
    for (int i = 0; i < 8; i++) step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t2_hold_cnt", 32'(count4), 32'd3);
    en = 1'b1;
    done_cyc = load_cyc + 999;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done4 && done_cyc == load_cyc + 999) done_cyc = cyc;
    end
    check("t2_done_lat", 32'(done_cyc - load_cyc), 32'd27);

    // 3: clamp and zero-load abort
    load_step(7'd120);
    check("t3_clamp", 32'(count4), 32'd99);
    step();
    step();
    load_step(7'd0);
    check("t3_zero_cnt", 32'(count4), 32'd0);
    check("t3_zero_busy", 32'(busy4), 32'd0);
    check("t3_zero_done", 32'(done4), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // 4: reload on the edge that would have completed the phase
    load_step(7'd1);
    for (int i = 0; i < 3; i++) step();
    load_step(7'd10);
    check("t4_reload_cnt", 32'(count4), 32'd10);
    check("t4_reload_busy", 32'(busy4), 32'd1);
    check("t4_reload_done", 32'(done4), 32'd0);
    gap = 999;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick4) begin
        gap = i;
        break;
      end
    end
    check("t4_tick_gap", 32'(gap), 32'd4);

    // 5: asynchronous reset mid-count
    load_step(7'd10);
    for (int i = 0; i < 20; i++) begin
      if (count4 == 7'd6) break;
      step();
    end
    check("t5_reach6", 32'(count4), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    n_tick = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick4 || tick1 || done4 || done1) n_tick++;
    end
    check("t5_quiet_after_rst", 32'(n_tick), 32'd0);

    // 6: divide-by-1 instance counts every cycle
    load_step(7'd3);
    check("t6_cnt_load", 32'(count1), 32'd3);
    done_cyc = load_cyc + 999;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i <= 3) check("t6_cnt_seq", 32'(count1), 32'(3 - i));
      if (done1 && done_cyc == load_cyc + 999) done_cyc = cyc;
    end
    check("t6_done_lat", 32'(done_cyc - load_cyc), 32'd3);
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
